// File: rtl/dcache_pkg.sv
// Shared types and address-split constants for the direct-mapped data cache.
package dcache_pkg;

  localparam int unsigned TAG_W      = 22;
  localparam int unsigned INDEX_W    = 5;
  localparam int unsigned OFFSET_W   = 5;
  localparam int unsigned WSEL_W     = 3;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned LINE_BITS  = 256;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_REFILL    = 2'd3
  } state_t;

  // Pick one 32-bit word out of a line by word-select.
  function automatic logic [WORD_W-1:0] get_word(input logic [LINE_BITS-1:0] line,
                                                 input logic [WSEL_W-1:0]    sel);
    return line[{sel, 5'b0} +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the direct-mapped cache.
// One asynchronous read port, one word-write port (store hit) and one
// line-write port (refill). Only valid/dirty bits are reset.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned LINE_W    = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [INDEX_W-1:0]   i_rd_idx,
  output logic [TAG_W-1:0]     o_rd_tag,
  output logic                 o_rd_valid,
  output logic                 o_rd_dirty,
  output logic [LINE_W-1:0]    o_rd_line,
  input  logic                 i_word_we,
  input  logic [INDEX_W-1:0]   i_word_idx,
  input  logic [WSEL_W-1:0]    i_word_sel,
  input  logic [WORD_W-1:0]    i_word_wdata,
  input  logic                 i_line_we,
  input  logic [INDEX_W-1:0]   i_line_idx,
  input  logic [TAG_W-1:0]     i_line_tag,
  input  logic [LINE_W-1:0]    i_line_wdata
);

  logic [NUM_LINES-1:0] r_valid;
  logic [NUM_LINES-1:0] r_dirty;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  // Asynchronous read of the addressed line.
  always_comb begin
    o_rd_tag   = r_tag[i_rd_idx];
    o_rd_valid = r_valid[i_rd_idx];
    o_rd_dirty = r_dirty[i_rd_idx];
    o_rd_line  = r_data[i_rd_idx];
  end

  // Valid/dirty bookkeeping: refill makes a line valid and clean, store hit dirties it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_line_we) begin
      r_valid[i_line_idx] <= 1'b1;
      r_dirty[i_line_idx] <= 1'b0;
    end else if (i_word_we) begin
      r_dirty[i_word_idx] <= 1'b1;
    end
  end

  // Tag and data arrays; no reset needed since valid gates their use.
  always_ff @(posedge i_clk) begin
    if (i_line_we) begin
      r_tag[i_line_idx]  <= i_line_tag;
      r_data[i_line_idx] <= i_line_wdata;
    end else if (i_word_we) begin
      r_data[i_word_idx][{i_word_sel, 5'b0} +: WORD_W] <= i_word_wdata;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller for the MEM stage.
// Hits complete with zero added latency; misses stall the pipeline while
// the FSM writes back a dirty victim (if any) and fetches the new line.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 32,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_wdata_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_wdata_o,
  input  logic [LINE_BITS-1:0] mem_rdata_i,
  input  logic                 mem_ack_i
);

  state_t                r_state;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [31:0]           r_mem_addr;
  logic [LINE_BITS-1:0]  r_mem_wdata;

  logic [TAG_W-1:0]      w_req_tag;
  logic [INDEX_W-1:0]    w_idx;
  logic [WSEL_W-1:0]     w_wsel;
  logic [TAG_W-1:0]      w_vic_tag;
  logic                  w_vic_valid;
  logic                  w_vic_dirty;
  logic [LINE_BITS-1:0]  w_line;
  logic                  w_hit;
  logic                  w_word_we;
  logic                  w_line_we;
  logic                  w_unused_addr;

  assign w_req_tag     = cpu_addr_i[31:10];
  assign w_idx         = cpu_addr_i[9:5];
  assign w_wsel        = cpu_addr_i[4:2];
  assign w_unused_addr = ^cpu_addr_i[1:0];

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .LINE_W    (LINE_BITS)
  ) u_sram (
    .i_clk        (clk_i),
    .i_rst        (rst_i),
    .i_rd_idx     (w_idx),
    .o_rd_tag     (w_vic_tag),
    .o_rd_valid   (w_vic_valid),
    .o_rd_dirty   (w_vic_dirty),
    .o_rd_line    (w_line),
    .i_word_we    (w_word_we),
    .i_word_idx   (w_idx),
    .i_word_sel   (w_wsel),
    .i_word_wdata (cpu_wdata_i),
    .i_line_we    (w_line_we),
    .i_line_idx   (w_idx),
    .i_line_tag   (w_req_tag),
    .i_line_wdata (mem_rdata_i)
  );

  // Hit detection, store-hit write enable, refill write enable, CPU outputs.
  always_comb begin
    w_hit       = (r_state == S_IDLE) && cpu_req_i && w_vic_valid && (w_vic_tag == w_req_tag);
    w_word_we   = w_hit && cpu_we_i;
    w_line_we   = (r_state == S_ALLOCATE) && mem_ack_i;
    cpu_rdata_o = get_word(w_line, w_wsel);
    // Stall is combinational so a miss freezes the pipeline in the miss cycle itself.
    cpu_stall_o = !rst_i && ((r_state != S_IDLE) || (cpu_req_i && !w_hit));
  end

  // Miss-handling FSM with registered memory-side outputs held until ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req_i && !w_hit) begin
            r_mem_req <= 1'b1;
            if (w_vic_valid && w_vic_dirty) begin
              r_state     <= S_WRITEBACK;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {w_vic_tag, w_idx, 5'b0};
              r_mem_wdata <= w_line;
            end else begin
              r_state    <= S_ALLOCATE;
              r_mem_we   <= 1'b0;
              r_mem_addr <= {w_req_tag, w_idx, 5'b0};
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            r_state    <= S_ALLOCATE;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_req_tag, w_idx, 5'b0};
          end
        end
        S_ALLOCATE: begin
          if (mem_ack_i) begin
            r_state   <= S_REFILL;
            r_mem_req <= 1'b0;
          end
        end
        S_REFILL: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_mem_we  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o   = r_mem_req;
  assign mem_we_o    = r_mem_we;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 SHALL have parameter NUM_LINES, default 32, number of direct-mapped lines (power of two).
REQ-002 SHALL have parameter LINE_BITS, default 256, line width (8 x 32-bit words).
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cpu_req_i  in  1  MEM-stage access valid (MemRead or MemWrite).
REQ-006 SHALL have port cpu_we_i  in  1  1 = store, 0 = load.
REQ-007 SHALL have port cpu_addr_i  in  32  byte address (EX_MEM ALU result).
REQ-008 SHALL have port cpu_wdata_i  in  32  store data.
REQ-009 SHALL have port cpu_rdata_o  out  32  load data, valid when cpu_stall_o=0.
REQ-010 SHALL have port cpu_stall_o  out  1  freezes the whole pipeline while high.
REQ-011 SHALL have port mem_req_o  out  1  memory request, held until acknowledged.
REQ-012 SHALL have port mem_we_o  out  1  1 = line write-back, 0 = line fetch.
REQ-013 SHALL have port mem_addr_o  out  32  line-aligned address, bits[4:0]=0.
REQ-014 SHALL have port mem_wdata_o  out  256  victim line.
REQ-015 SHALL have port mem_rdata_i  in  256  fetched line, valid with mem_ack_i.
REQ-016 SHALL have port mem_ack_i  in  1  one-cycle completion pulse.

Function
REQ-017 Address split SHALL be offset[4:0], word select[4:2], index[9:5], tag[31:10]; bits[1:0] ignored.
REQ-018 Hit SHALL mean cpu_req_i & valid[index] & (tag[index]==addr tag), evaluated combinationally in IDLE.
REQ-019 Load hit SHALL drive cpu_rdata_o combinationally with the selected word, cpu_stall_o=0, zero added latency.
REQ-020 Store hit SHALL write the selected word and set dirty[index] on the same clock edge, cpu_stall_o=0.
REQ-021 Miss SHALL assert cpu_stall_o combinationally in the miss cycle and keep it high until the access hits.
REQ-022 FSM states SHALL be IDLE, WRITEBACK, ALLOCATE, REFILL.
REQ-023 IDLE on miss: victim valid & dirty -> WRITEBACK, else -> ALLOCATE.
REQ-024 WRITEBACK SHALL drive mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_wdata_o=victim line; on mem_ack_i -> ALLOCATE.
REQ-025 ALLOCATE SHALL drive mem_req_o=1, mem_we_o=0, mem_addr_o={req tag, index, 5'b0}; on mem_ack_i write mem_rdata_i, set tag, valid=1, dirty=0, -> REFILL.
REQ-026 REFILL SHALL last one cycle with mem_req_o=0 and then return to IDLE, where the access re-evaluates as a hit.
REQ-027 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o SHALL remain stable from assertion until the ack cycle.
REQ-028 mem_ack_i SHALL be ignored in IDLE and REFILL.
REQ-029 cpu_req_i=0 in IDLE SHALL give cpu_stall_o=0 and no state change.
REQ-030 The CPU holds cpu_* inputs constant while stalled; the block SHALL NOT re-latch them.
REQ-031 cpu_stall_o SHALL be 0 whenever cpu_req_i=0 and the FSM is in IDLE.

Reset
REQ-032 rst_i SHALL immediately force IDLE, clear all valid and dirty bits, and drive mem_req_o=0, mem_we_o=0, cpu_stall_o=0.
REQ-033 Reset during WRITEBACK/ALLOCATE SHALL abort the transfer; a late mem_ack_i after release SHALL be ignored.
REQ-034 Tag and data arrays SHALL NOT require reset.

Structure
REQ-035 A shared package dcache_pkg SHALL hold the state enum, TAG_W=22, INDEX_W=5, OFFSET_W=5, LINE_BITS.
REQ-036 Storage SHALL be one sub-module dcache_sram (tag, valid, dirty, data arrays; word-write and line-write ports); FSM and hit logic stay in dcache_controller.

Verification
REQ-037 After reset, load 0x0000_0040 -> stall=1, ALLOCATE req addr 0x40 we=0; ack with line word0=0x1111_1111 -> after REFILL, rdata=0x1111_1111, stall=0.
REQ-038 Store 0xDEAD_BEEF to 0x44 (hit) -> no stall; load 0x44 next cycle -> 0xDEAD_BEEF.
REQ-039 Load 0x0000_0440 (same index, new tag) -> WRITEBACK addr 0x40 we=1 with word1=0xDEAD_BEEF, then ALLOCATE addr 0x440.
REQ-040 Delay mem_ack_i 10 cycles -> request outputs stable, stall high for all 10 cycles.
REQ-041 Assert rst_i mid-ALLOCATE, then ack -> mem_req_o=0 at once, ack ignored, load of 0x40 misses.
